// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I decode queue.
// Holds the opcode map, the one-hot instruction-type codes, the canonical
// NOP, the decoded-entry record and the width that the queue stores per entry.
package decode_pkg;

    // Base RV32I opcodes that the decoder recognises
    localparam logic [6:0] R_Type       = 7'b0110011;
    localparam logic [6:0] I_Type_ALU   = 7'b0010011;
    localparam logic [6:0] I_Type_LOAD  = 7'b0000011;
    localparam logic [6:0] I_Type_JALR  = 7'b1100111;
    localparam logic [6:0] S_Type       = 7'b0100011;
    localparam logic [6:0] B_Type       = 7'b1100011;
    localparam logic [6:0] U_Type_LUI   = 7'b0110111;
    localparam logic [6:0] U_Type_AUIPC = 7'b0010111;
    localparam logic [6:0] J_Type       = 7'b1101111;
    localparam logic [6:0] I_Type_ECALL = 7'b1110011;

    // One-hot instruction type; all-zero means unrecognised
    localparam logic [6:0] TYP_R    = 7'b0000001;
    localparam logic [6:0] TYP_I    = 7'b0000010;
    localparam logic [6:0] TYP_S    = 7'b0000100;
    localparam logic [6:0] TYP_B    = 7'b0001000;
    localparam logic [6:0] TYP_U    = 7'b0010000;
    localparam logic [6:0] TYP_J    = 7'b0100000;
    localparam logic [6:0] TYP_NONE = 7'b0000000;

    localparam logic [31:0] NOOP = 32'h00000013;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  fun3;
        logic [6:0]  fun7;
        logic [31:0] imm;
        logic [6:0]  inst_typ;
        logic [6:0]  opcode;
        logic        illegal;
    } dec_t;

    localparam int DEC_W = $bits(dec_t);

    // funct7 values permitted for R-type and the immediate shifts
    function automatic logic f7_ok(input logic [6:0] f7);
        return (f7 == 7'b0000000) || (f7 == 7'b0100000);
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I field extractor.
// Ports:
//   instr_i  in   32     raw instruction
//   dec_o    out  DEC_W  packed dec_t: fields, immediate, one-hot type, opcode, illegal
module decode_comb
    import decode_pkg::*;
(
    input  logic [31:0]      instr_i,
    output logic [DEC_W-1:0] dec_o
);

    dec_t dec_s;

    // Extract fields per opcode class, then classify illegal encodings
    always_comb begin
        dec_s = '0;
        case (instr_i[6:0])
            R_Type: begin
                dec_s.rd       = instr_i[11:7];
                dec_s.fun3     = instr_i[14:12];
                dec_s.rs1      = instr_i[19:15];
                dec_s.rs2      = instr_i[24:20];
                dec_s.fun7     = instr_i[31:25];
                dec_s.inst_typ = TYP_R;
            end
            I_Type_ALU, I_Type_LOAD, I_Type_JALR, I_Type_ECALL: begin
                dec_s.rd       = instr_i[11:7];
                dec_s.fun3     = instr_i[14:12];
                dec_s.rs1      = instr_i[19:15];
                dec_s.fun7     = instr_i[31:25];
                dec_s.imm      = {{20{instr_i[31]}}, instr_i[31:20]};
                dec_s.inst_typ = TYP_I;
            end
            S_Type: begin
                dec_s.fun3     = instr_i[14:12];
                dec_s.rs1      = instr_i[19:15];
                dec_s.rs2      = instr_i[24:20];
                dec_s.imm      = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                dec_s.inst_typ = TYP_S;
            end
            B_Type: begin
                dec_s.fun3     = instr_i[14:12];
                dec_s.rs1      = instr_i[19:15];
                dec_s.rs2      = instr_i[24:20];
                dec_s.imm      = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                                  instr_i[11:8], 1'b0};
                dec_s.inst_typ = TYP_B;
            end
            U_Type_LUI, U_Type_AUIPC: begin
                dec_s.rd       = instr_i[11:7];
                dec_s.imm      = {instr_i[31:12], 12'b0};
                dec_s.inst_typ = TYP_U;
            end
            J_Type: begin
                dec_s.rd       = instr_i[11:7];
                dec_s.imm      = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                                  instr_i[30:21], 1'b0};
                dec_s.inst_typ = TYP_J;
            end
            default: begin
                dec_s = '0;
            end
        endcase
        if (dec_s.inst_typ != TYP_NONE) begin
            dec_s.opcode = instr_i[6:0];
        end else begin
            dec_s.opcode = 7'b0000000;
        end
        // Immediate shifts (funct3 001/101 under OP-IMM) constrain funct7 like R-type
        dec_s.illegal = (instr_i[1:0] != 2'b11)
                      | (dec_s.inst_typ == TYP_NONE)
                      | ((dec_s.inst_typ == TYP_R) & ~f7_ok(dec_s.fun7))
                      | ((instr_i[6:0] == I_Type_ALU) & (instr_i[13:12] == 2'b01)
                         & ~f7_ok(dec_s.fun7));
    end

    assign dec_o = dec_s;

endmodule

// File: rtl/decode_queue.sv
// Registered RV32I decode stage with a DEPTH-entry FIFO of decoded instructions.
// Ports:
//   i_clk, i_rst (sync, active-high), i_en (global stall), i_flush (drop all)
//   i_valid/o_ready/instruction/i_pc   : fetch side
//   o_valid/i_ready + head fields      : backend side (all zero when empty)
//   count_o                            : occupied entries
module decode_queue
    import decode_pkg::*;
#(
    parameter int N_param = 32,
    parameter int PC_W    = 32,
    parameter int DEPTH   = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic                     i_flush,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [N_param-1:0]       instruction,
    input  logic [PC_W-1:0]          i_pc,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [4:0]               rd_o,
    output logic [4:0]               rs1_o,
    output logic [4:0]               rs2_o,
    output logic [2:0]               fun3_o,
    output logic [6:0]               fun7_o,
    output logic [31:0]              imm_o,
    output logic [6:0]               INST_typ_o,
    output logic [6:0]               opcode_o,
    output logic [PC_W-1:0]          pc_o,
    output logic                     illegal_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DEC_W + PC_W;

    logic [DEC_W-1:0] dec_s;
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_s, pop_s;
    dec_t             head_s;
    logic [PC_W-1:0]  head_pc_s;

    decode_comb u_decode_comb (
        .instr_i (instruction[31:0]),
        .dec_o   (dec_s)
    );

    assign o_ready = (count_q < CNT_W'(DEPTH));
    assign o_valid = (count_q != '0);
    assign count_o = count_q;
    assign push_s  = i_en & i_valid & o_ready & ~i_flush;
    assign pop_s   = i_en & o_valid & i_ready & ~i_flush;

    // Next-state for pointers and occupancy; stall holds, flush clears
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (i_en & i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; no reset needed because outputs are masked by o_valid
    always_ff @(posedge i_clk) begin
        if (push_s & ~i_rst) begin
            mem_q[wr_ptr_q] <= {dec_s, i_pc};
        end
    end

    assign head_s    = dec_t'(mem_q[rd_ptr_q][ENT_W-1:PC_W]);
    assign head_pc_s = mem_q[rd_ptr_q][PC_W-1:0];

    // Head outputs forced to zero while the queue is empty
    always_comb begin
        rd_o       = 5'd0;
        rs1_o      = 5'd0;
        rs2_o      = 5'd0;
        fun3_o     = 3'd0;
        fun7_o     = 7'd0;
        imm_o      = 32'd0;
        INST_typ_o = 7'd0;
        opcode_o   = 7'd0;
        pc_o       = '0;
        illegal_o  = 1'b0;
        if (o_valid) begin
            rd_o       = head_s.rd;
            rs1_o      = head_s.rs1;
            rs2_o      = head_s.rs2;
            fun3_o     = head_s.fun3;
            fun7_o     = head_s.fun7;
            imm_o      = head_s.imm;
            INST_typ_o = head_s.inst_typ;
            opcode_o   = head_s.opcode;
            pc_o       = head_pc_s;
            illegal_o  = head_s.illegal;
        end else begin
            illegal_o  = 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: a queue-based reference model checked
// every cycle, plus hand-computed literal expectations for the directed cases.
module tb_decode_queue;
    import decode_pkg::*;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1, en = 1'b1, flush = 1'b0, vin = 1'b0, rdy = 1'b0;
    logic [31:0] instr = 32'h0, pc = 32'h0;
    logic        o_ready, o_valid, illegal_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [2:0]  fun3_o;
    logic [6:0]  fun7_o, typ_o, opcode_o;
    logic [31:0] imm_o, pc_o;
    logic [CW-1:0] count_o;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    decode_queue #(.N_param(32), .PC_W(32), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_flush(flush), .i_valid(vin),
        .o_ready(o_ready), .instruction(instr), .i_pc(pc), .o_valid(o_valid),
        .i_ready(rdy), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .fun3_o(fun3_o),
        .fun7_o(fun7_o), .imm_o(imm_o), .INST_typ_o(typ_o), .opcode_o(opcode_o),
        .pc_o(pc_o), .illegal_o(illegal_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7, typ, op;
        logic [31:0] imm, pc;
        logic        ill;
    } ent_t;

    ent_t mq[$];

    // Reference decode written straight from the RV32I format table
    function automatic ent_t ref_dec(input logic [31:0] i, input logic [31:0] p);
        ent_t e;
        logic [6:0] op;
        e = '{default: '0};
        op = i[6:0];
        e.pc = p;
        if (op == 7'h33) begin
            e.typ = 7'd1; e.rd = i[11:7]; e.f3 = i[14:12]; e.rs1 = i[19:15];
            e.rs2 = i[24:20]; e.f7 = i[31:25];
        end else if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73) begin
            e.typ = 7'd2; e.rd = i[11:7]; e.f3 = i[14:12]; e.rs1 = i[19:15];
            e.f7 = i[31:25]; e.imm = $signed(i[31:20]);
        end else if (op == 7'h23) begin
            e.typ = 7'd4; e.f3 = i[14:12]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
            e.imm = $signed({i[31:25], i[11:7]});
        end else if (op == 7'h63) begin
            e.typ = 7'd8; e.f3 = i[14:12]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
            e.imm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
        end else if (op == 7'h37 || op == 7'h17) begin
            e.typ = 7'd16; e.rd = i[11:7]; e.imm = i[31:12] * 32'd4096;
        end else if (op == 7'h6F) begin
            e.typ = 7'd32; e.rd = i[11:7];
            e.imm = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
        end
        if (e.typ != 7'd0) e.op = op;
        e.ill = (i[1:0] != 2'b11) || (e.typ == 7'd0)
             || (e.typ == 7'd1 && e.f7 != 7'h00 && e.f7 != 7'h20)
             || (op == 7'h13 && (e.f3 == 3'd1 || e.f3 == 3'd5) && e.f7 != 7'h00 && e.f7 != 7'h20);
        return e;
    endfunction

    // Reference queue update on every rising edge
    always @(posedge clk) begin
        bit m_push, m_pop;
        if (rst) begin
            mq.delete();
            chk_on = 1'b1;
        end else if (en) begin
            m_push = vin && (mq.size() < DEPTH) && !flush;
            m_pop  = (mq.size() > 0) && rdy && !flush;
            if (flush) mq.delete();
            else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) mq.push_back(ref_dec(instr, pc));
            end
        end
    end

    function automatic logic [107:0] expected();
        ent_t h;
        logic v;
        v = (mq.size() > 0);
        h = '{default: '0};
        if (v) h = mq[0];
        return {v, (mq.size() < DEPTH), CW'(mq.size()), h.rd, h.rs1, h.rs2, h.f3,
                h.f7, h.imm, h.typ, h.op, h.pc, h.ill};
    endfunction

    // Whole-output compare against the model, 1 time unit after each edge
    always @(posedge clk) begin
        logic [107:0] act, exp_v;
        #1;
        if (chk_on) begin
            act = {o_valid, o_ready, count_o, rd_o, rs1_o, rs2_o, fun3_o, fun7_o,
                   imm_o, typ_o, opcode_o, pc_o, illegal_o};
            exp_v = expected();
            vectors++;
            if (act !== exp_v) begin
                miscompares++;
                $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, act, exp_v);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] tbl [16];

    initial begin
        tbl = '{32'h00510093, NOOP, 32'hFE000EE3, 32'h0000007F, 32'hFE000033,
                32'h40000033, 32'h00A12023, 32'h123450B7, 32'h004000EF, 32'h40115093,
                32'h7E111093, 32'h00008067, 32'h00000073, 32'h00002003, 32'h00000017,
                32'h00000011};
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_imm", imm_o, 32'd0);

        // 1: ADDI x1,x2,5 with backend ready
        vin = 1'b1; instr = 32'h00510093; pc = 32'h100; rdy = 1'b1;
        cyc();
        chk("addi_valid", 32'(o_valid), 32'd1);
        chk("addi_rd", 32'(rd_o), 32'd1);
        chk("addi_rs1", 32'(rs1_o), 32'd2);
        chk("addi_imm", imm_o, 32'd5);
        chk("addi_typ", 32'(typ_o), 32'h02);
        chk("addi_ill", 32'(illegal_o), 32'd0);
        vin = 1'b0;
        cyc();
        chk("addi_popped", 32'(o_valid), 32'd0);

        // 2: fill to DEPTH with backend stalled, then drain in order
        rdy = 1'b0; vin = 1'b1; instr = NOOP;
        pc = 32'h200; cyc(); chk("fill_cnt1", 32'(count_o), 32'd1);
        pc = 32'h204; cyc(); chk("fill_cnt2", 32'(count_o), 32'd2);
        chk("full_ready", 32'(o_ready), 32'd0);
        pc = 32'h208; cyc(); chk("full_hold", 32'(count_o), 32'd2);
        chk("full_head", pc_o, 32'h200);
        vin = 1'b0; rdy = 1'b1;
        cyc(); chk("drain_head", pc_o, 32'h204);
        cyc(); chk("drain_empty", 32'(count_o), 32'd0);

        // 3: BEQ x0,x0,-4
        rdy = 1'b0; vin = 1'b1; instr = 32'hFE000EE3; pc = 32'h300;
        cyc();
        chk("beq_imm", imm_o, 32'hFFFFFFFC);
        chk("beq_typ", 32'(typ_o), 32'h08);
        chk("beq_rd", 32'(rd_o), 32'd0);
        vin = 1'b0; rdy = 1'b1; cyc();

        // 4: unknown opcode, then R-type with bad funct7
        rdy = 1'b0; vin = 1'b1; instr = 32'h0000007F; pc = 32'h400;
        cyc();
        chk("unk_ill", 32'(illegal_o), 32'd1);
        chk("unk_typ", 32'(typ_o), 32'h00);
        instr = 32'hFE000033; pc = 32'h404;
        cyc();
        vin = 1'b0; rdy = 1'b1;
        cyc();
        chk("badf7_ill", 32'(illegal_o), 32'd1);
        chk("badf7_typ", 32'(typ_o), 32'h01);

        // 5: flush while full with a valid input, and while partly full
        rdy = 1'b0; vin = 1'b1; instr = 32'h00A00093; pc = 32'h500;
        cyc(); chk("pre_flush_cnt", 32'(count_o), 32'd2);
        flush = 1'b1; cyc();
        chk("flush_cnt", 32'(count_o), 32'd0);
        chk("flush_valid", 32'(o_valid), 32'd0);
        flush = 1'b0; vin = 1'b0; cyc();
        chk("flush_dropped", 32'(count_o), 32'd0);
        vin = 1'b1; cyc();
        flush = 1'b1; rdy = 1'b1; cyc();
        chk("flush_part", 32'(count_o), 32'd0);
        flush = 1'b0;

        // 6: reset overrides push/pop, then stall holds state
        rdy = 1'b0; vin = 1'b1; pc = 32'h600;
        cyc(); cyc();
        rst = 1'b1; rdy = 1'b1; cyc();
        chk("rst_mid_cnt", 32'(count_o), 32'd0);
        chk("rst_mid_valid", 32'(o_valid), 32'd0);
        chk("rst_mid_imm", imm_o, 32'd0);
        chk("rst_mid_ready", 32'(o_ready), 32'd1);
        rst = 1'b0; rdy = 1'b0; pc = 32'h700; instr = 32'h123450B7;
        cyc();
        en = 1'b0; rdy = 1'b1; pc = 32'h704; instr = NOOP;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_cnt", 32'(count_o), 32'd1);
            chk("stall_pc", pc_o, 32'h700);
        end
        en = 1'b1; cyc();
        chk("pushpop_cnt", 32'(count_o), 32'd1);
        chk("pushpop_pc", pc_o, 32'h704);

        // Mixed traffic checked against the model only
        for (int k = 0; k < 400; k++) begin
            rst   = ($urandom_range(0, 99) == 0);
            en    = ($urandom_range(0, 7) != 0);
            flush = ($urandom_range(0, 15) == 0);
            vin   = $urandom_range(0, 1);
            rdy   = $urandom_range(0, 1);
            instr = tbl[$urandom_range(0, 15)];
            pc    = $urandom;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
